// File: rtl/dla_hld_ram_pkg.sv
// Shared constants and parameter helpers for the dla_hld_ram read-side wrappers.
// Also provides the elaboration-time parameter legality macro.
`ifndef DLA_ACL_PARAMETER_ASSERT
`define DLA_ACL_PARAMETER_ASSERT(cond) \
   if (!(cond)) begin : g_illegal_parameter \
      $error("dla_hld_ram: illegal parameter combination"); \
   end
`endif

package dla_hld_ram_pkg;

   localparam int MAX_READ_LATENCY = 4;

   function automatic int read_latency(input int register_b_address, input int register_b_readdata);
      return 32'sd1 + register_b_address + register_b_readdata;
   endfunction

   function automatic int min_full_rate_depth(input int lat);
      return lat + 32'sd1;
   endfunction

endpackage

// File: rtl/dla_hld_ram_rsp_fifo.sv
// Circular response FIFO with a registered head; DEPTH need not be a power of two.
// The head register always mirrors the oldest stored entry, so it holds under backpressure.
module dla_hld_ram_rsp_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic                         head_valid,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
   logic [CW-1:0]    count_r, count_nxt_s;
   logic [WIDTH-1:0] head_r, head_nxt_s;
   logic             head_valid_r, do_pop_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Next pointer, count and head value; pop on an empty FIFO is ignored.
   always_comb begin
      do_pop_s     = pop & (count_r != {CW{1'b0}});
      rd_ptr_nxt_s = do_pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      count_nxt_s  = count_r + CW'(push) - CW'(do_pop_s);
      if (do_pop_s && (count_r > CW'(1))) begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end else if (push && ((count_r == {CW{1'b0}}) || do_pop_s)) begin
         head_nxt_s = push_data;
      end else begin
         head_nxt_s = head_r;
      end
   end

   // Storage array; contents need no reset because the count qualifies them.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers, occupancy and registered head.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         head_r       <= {WIDTH{1'b0}};
         head_valid_r <= 1'b0;
      end else begin
         wr_ptr_r     <= push ? ptr_inc(wr_ptr_r) : wr_ptr_r;
         rd_ptr_r     <= rd_ptr_nxt_s;
         count_r      <= count_nxt_s;
         head_r       <= head_nxt_s;
         head_valid_r <= (count_nxt_s != {CW{1'b0}});
      end
   end

   assign head_valid = head_valid_r;
   assign head_data  = head_r;
   assign count      = count_r;

   dla_hld_ram_rsp_fifo_checker #(.DEPTH(DEPTH)) u_checker (
      .clock  (clock),
      .resetn (resetn),
      .push   (push),
      .count  (count_r)
   );

endmodule

// Overflow monitor: credit accounting must make a push into a full FIFO impossible.
module dla_hld_ram_rsp_fifo_checker #(
   parameter int DEPTH = 3
) (
   input logic                       clock,
   input logic                       resetn,
   input logic                       push,
   input logic [$clog2(DEPTH+1)-1:0] count
);

   overflow_a: assert property (@(posedge clock) disable iff (!resetn)
      !(push && (count == ($clog2(DEPTH+1))'(DEPTH))));

endmodule

// File: rtl/dla_hld_ram_read_rsp_buffer.sv
// Valid/ready wrapper around the fixed-latency RAM read port: reads issue only with a
// guaranteed FIFO slot, so landing data is never dropped and responses stay in order.
module dla_hld_ram_read_rsp_buffer
   import dla_hld_ram_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int ADDR         = 9,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 3
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [ADDR-1:0]  req_address,
   output logic [ADDR-1:0]  ram_address,
   output logic             ram_read_enable,
   input  logic [WIDTH-1:0] ram_readdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   `DLA_ACL_PARAMETER_ASSERT((READ_LATENCY >= 1) && (READ_LATENCY <= MAX_READ_LATENCY) && (FIFO_DEPTH >= 1))

   logic [READ_LATENCY-1:0] inflight_r;
   logic                    ready_en_r, busy_r;
   logic                    land_s, accept_s, pop_s;
   logic [CW-1:0]           inflight_count_s, fifo_count_s, used_s, used_nxt_s;

   // Credit accounting: every accepted read owns a FIFO slot until it is popped.
   always_comb begin
      inflight_count_s = {CW{1'b0}};
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight_count_s = inflight_count_s + CW'(inflight_r[i]);
      end
      used_s     = inflight_count_s + fifo_count_s;
      pop_s      = rsp_valid & rsp_ready;
      req_ready  = ready_en_r & ((used_s < CW'(FIFO_DEPTH)) | pop_s);
      accept_s   = req_valid & req_ready;
      used_nxt_s = used_s + CW'(accept_s) - CW'(pop_s);
      land_s     = inflight_r[READ_LATENCY-1];
   end

   // In-flight tracker: the last stage marks the cycle the RAM output is valid.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         inflight_r <= {READ_LATENCY{1'b0}};
         ready_en_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         inflight_r[0] <= accept_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            inflight_r[i] <= inflight_r[i-1];
         end
         ready_en_r <= 1'b1;
         busy_r     <= (used_nxt_s != {CW{1'b0}});
      end
   end

   assign ram_address     = req_address;
   assign ram_read_enable = accept_s;
   assign busy            = busy_r;

   dla_hld_ram_rsp_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock      (clock),
      .resetn     (resetn),
      .push       (land_s),
      .push_data  (ram_readdata),
      .pop        (pop_s),
      .head_valid (rsp_valid),
      .head_data  (rsp_data),
      .count      (fifo_count_s)
   );

endmodule

// File: tb/tb_dla_hld_ram_read_rsp_buffer.sv
// Self-checking bench: behavioural RAM with READ_LATENCY delay plus an in-order
// scoreboard of expected read data captured at request acceptance.
module tb_dla_hld_ram_read_rsp_buffer;

   localparam int W = 32;
   localparam int A = 9;
   localparam int L = 2;
   localparam int D = 3;

   logic          clock = 1'b0;
   logic          resetn = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [A-1:0]  req_address = '0;
   logic [A-1:0]  ram_address;
   logic          ram_read_enable;
   logic [W-1:0]  ram_readdata;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [W-1:0]  rsp_data;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [W-1:0] mem [512];
   logic [W-1:0] ram_pipe [L];
   logic [W-1:0] exp_q [$];
   logic [W-1:0] got_q [$];
   int           acc_cyc_q [$];
   int           pop_cyc_q [$];

   dla_hld_ram_read_rsp_buffer #(.WIDTH(W), .ADDR(A), .READ_LATENCY(L), .FIFO_DEPTH(D)) dut (
      .clock           (clock),
      .resetn          (resetn),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_address     (req_address),
      .ram_address     (ram_address),
      .ram_read_enable (ram_read_enable),
      .ram_readdata    (ram_readdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // RAM model: fixed latency, never reset, garbage on cycles without a read
   always @(posedge clock) begin
      ram_pipe[0] <= ram_read_enable ? mem[ram_address] : $urandom();
      for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
   end
   assign ram_readdata = ram_pipe[L-1];

   // Scoreboard capture: expected data at acceptance, observed data at pop
   always @(negedge clock) begin
      if (!resetn) begin
         exp_q.delete(); got_q.delete(); acc_cyc_q.delete(); pop_cyc_q.delete();
      end else begin
         if (req_valid && req_ready) begin
            exp_q.push_back(mem[req_address]);
            acc_cyc_q.push_back(cyc);
         end
         if (rsp_valid && rsp_ready) begin
            got_q.push_back(rsp_data);
            pop_cyc_q.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_sb();
      exp_q.delete(); got_q.delete(); acc_cyc_q.delete(); pop_cyc_q.delete();
   endtask

   task automatic test_reset();
      resetn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      repeat (3) tick();
      @(negedge clock);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
      tick();
      resetn = 1'b1;
      @(negedge clock);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL release_cycle_req_ready: got %b expected 0", req_ready); end
      tick();
      @(negedge clock);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL after_release_req_ready: got %b expected 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL after_release_idle: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
   endtask

   task automatic test_single();
      int ta;
      int tr;
      tick();
      clear_sb();
      mem[5] = 32'hDEADBEEF;
      req_valid = 1'b1; req_address = 9'd5; rsp_ready = 1'b1;
      @(negedge clock);
      ta = cyc;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %b expected 1", req_ready); end
      tick();
      req_valid = 1'b0;
      tr = -1;
      for (int k = 0; k < 20 && tr < 0; k++) begin
         @(negedge clock);
         if (rsp_valid === 1'b1) tr = cyc;
         else tick();
      end
      checks++; if (tr - ta != L + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", tr - ta, L + 1); end
      checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", rsp_data); end
      tick();
      @(negedge clock);
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b valid=%b expected 0 0", busy, rsp_valid); end
   endtask

   task automatic test_stream();
      int not_ready = 0;
      tick();
      clear_sb();
      for (int i = 0; i < 16; i++) mem[i] = 32'(i * 3);
      rsp_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         req_valid = 1'b1; req_address = 9'(i);
         @(negedge clock);
         if (req_ready !== 1'b1) not_ready++;
         tick();
      end
      req_valid = 1'b0;
      for (int k = 0; k < 40 && got_q.size() < 16; k++) tick();
      checks++; if (not_ready != 0) begin errors++; $display("FAIL stream_req_ready: got %0d stalls expected 0", not_ready); end
      checks++; if (got_q.size() != 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", got_q.size()); end
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== 32'(i * 3)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, got_q[i], 32'(i * 3)); end
      end
      if (got_q.size() == 16 && acc_cyc_q.size() == 16) begin
         checks++; if (pop_cyc_q[15] - pop_cyc_q[0] != 15) begin errors++; $display("FAIL stream_bubbles: got span %0d expected 15", pop_cyc_q[15] - pop_cyc_q[0]); end
         checks++; if (pop_cyc_q[0] - acc_cyc_q[0] != L + 1) begin errors++; $display("FAIL stream_latency: got %0d expected %0d", pop_cyc_q[0] - acc_cyc_q[0], L + 1); end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] first;
      int held_bad = 0;
      int ready_bad = 0;
      tick();
      clear_sb();
      rsp_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         req_valid = (acc_cyc_q.size() < 5);
         req_address = 9'($urandom_range(0, 511));
         tick();
      end
      req_valid = 1'b1;
      @(negedge clock);
      checks++; if (acc_cyc_q.size() != D) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", acc_cyc_q.size(), D); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b expected 0", req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_q[0]) begin errors++; $display("FAIL bp_head: got valid=%b data=%h expected 1 %h", rsp_valid, rsp_data, exp_q[0]); end
      first = exp_q[0];
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clock);
         if (rsp_data !== first || rsp_valid !== 1'b1) held_bad++;
         if (req_ready !== 1'b0) ready_bad++;
      end
      checks++; if (held_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d changed cycles expected 0", held_bad); end
      checks++; if (ready_bad != 0) begin errors++; $display("FAIL bp_ready_held_low: got %0d high cycles expected 0", ready_bad); end
      tick();
      req_valid = 1'b0; rsp_ready = 1'b1;
      for (int k = 0; k < 20 && got_q.size() < D; k++) tick();
      checks++; if (got_q.size() != D) begin errors++; $display("FAIL bp_drain_count: got %0d expected %0d", got_q.size(), D); end
      for (int i = 0; i < D && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_drain[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      req_valid = 1'b1; req_address = 9'($urandom_range(0, 511));
      @(negedge clock);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b expected 1", req_ready); end
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 20 && busy !== 1'b0; k++) tick();
   endtask

   task automatic test_credit_boundary();
      tick();
      clear_sb();
      rsp_ready = 1'b0;
      for (int k = 0; k < 10 && acc_cyc_q.size() < D; k++) begin
         req_valid = 1'b1; req_address = 9'($urandom_range(0, 511));
         tick();
      end
      req_valid = 1'b0;
      repeat (L + 2) tick();
      @(negedge clock);
      checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL credit_full: got ready=%b valid=%b busy=%b expected 0 1 1", req_ready, rsp_valid, busy); end
      tick();
      rsp_ready = 1'b1; req_valid = 1'b1; req_address = 9'($urandom_range(0, 511));
      @(negedge clock);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL credit_pop_frees: got %b expected 1", req_ready); end
      tick();
      req_valid = 1'b0;
      for (int k = 0; k < 20 && got_q.size() < D + 1; k++) tick();
      checks++; if (got_q.size() != D + 1) begin errors++; $display("FAIL credit_drain_count: got %0d expected %0d", got_q.size(), D + 1); end
      for (int i = 0; i < D + 1 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL credit_drain[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      int outst = 0;
      int ready_bad = 0;
      int busy_bad = 0;
      logic acc, pp;
      tick();
      clear_sb();
      for (int i = 0; i < 512; i++) mem[i] = $urandom();
      for (int k = 0; k < 400; k++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         rsp_ready = ($urandom_range(0, 2) != 0);
         req_address = 9'($urandom_range(0, 511));
         @(negedge clock);
         pp  = rsp_valid & rsp_ready;
         acc = req_valid & req_ready;
         if (req_ready !== ((outst < D) || pp)) ready_bad++;
         if (busy !== (outst != 0)) busy_bad++;
         outst = outst + int'(acc) - int'(pp);
         tick();
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      for (int k = 0; k < 30 && got_q.size() < exp_q.size(); k++) tick();
      checks++; if (ready_bad != 0) begin errors++; $display("FAIL random_req_ready: got %0d bad cycles expected 0", ready_bad); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL random_busy: got %0d bad cycles expected 0", busy_bad); end
      checks++; if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin errors++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_mid_reset();
      int stale = 0;
      tick();
      clear_sb();
      rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req_valid = 1'b1; req_address = 9'($urandom_range(0, 511));
         @(negedge clock);
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_accept%0d: got %b expected 1", k, req_ready); end
         tick();
      end
      req_valid = 1'b0;
      resetn = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_clear: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
      tick();
      resetn = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) stale++;
         tick();
      end
      checks++; if (stale != 0) begin errors++; $display("FAIL midreset_stale: got %0d cycles expected 0", stale); end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midreset_pops: got %0d expected 0", got_q.size()); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = $urandom();
      #2;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_credit_boundary();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
